// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  mem_stage_pkg
//  Shared widths, FSM state type and constants for the MEM pipeline stage.
//  Revision: 1.0
// ============================================================================
package mem_stage_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 4;

  localparam logic [3:0] R0 = 4'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage : mem_stage_pkg
`default_nettype wire

// File: rtl/mem_fwd_unit.sv
`default_nettype none
// ============================================================================
//  mem_fwd_unit
//  WB-to-MEM store-data forwarding: register compare plus store-data mux.
//  Revision: 1.0
// ============================================================================
module mem_fwd_unit
#(
  parameter int DATA_W = mem_stage_pkg::DATA_W,
  parameter int REG_W  = mem_stage_pkg::REG_W
) (
  input  logic              wb_regwrite,
  input  logic [REG_W-1:0]  wb_dst_reg,
  input  logic [DATA_W-1:0] wb_write_data,
  input  logic [REG_W-1:0]  mem_rt,
  input  logic [DATA_W-1:0] mem_read_data2,
  output logic [DATA_W-1:0] store_data
);
  import mem_stage_pkg::*;

  logic w_hit;

  // R0 is hardwired to zero, so a write-back to it must never be forwarded
  assign w_hit = wb_regwrite && (wb_dst_reg == mem_rt) && (wb_dst_reg != REG_W'(R0));

  assign store_data = w_hit ? wb_write_data : mem_read_data2;

endmodule : mem_fwd_unit
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  mem_access_ctrl
//  MEM-stage req/ready data-memory controller with pipeline stall generation.
//  Optional WB-to-MEM store forwarding enabled by defining MEM_FWD_EN.
//  Revision: 1.0
// ============================================================================
module mem_access_ctrl
#(
  parameter int DATA_W = mem_stage_pkg::DATA_W,
  parameter int REG_W  = mem_stage_pkg::REG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_memwrite,
  input  logic              mem_memread,
  input  logic [DATA_W-1:0] mem_alu_val,
  input  logic [DATA_W-1:0] mem_read_data2,
  input  logic [REG_W-1:0]  mem_rt,
  input  logic              wb_regwrite,
  input  logic [REG_W-1:0]  wb_dst_reg,
  input  logic [DATA_W-1:0] wb_write_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              mem_stall,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata
);
  import mem_stage_pkg::*;

  mem_state_t        state_q, state_d;
  logic              req_q, we_q;
  logic [DATA_W-1:0] addr_q, wdata_q, rdata_q;

  logic              w_pending;
  logic [DATA_W-1:0] w_store_data;

  assign w_pending = mem_memread | mem_memwrite;

`ifdef MEM_FWD_EN
  mem_fwd_unit #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_fwd (
    .wb_regwrite    (wb_regwrite),
    .wb_dst_reg     (wb_dst_reg),
    .wb_write_data  (wb_write_data),
    .mem_rt         (mem_rt),
    .mem_read_data2 (mem_read_data2),
    .store_data     (w_store_data)
  );
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{wb_regwrite, wb_dst_reg, wb_write_data, mem_rt};
  assign w_store_data = mem_read_data2;
`endif

  always_comb begin
    state_d   = state_q;
    mem_stall = 1'b0;
    mem_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_pending) begin
          mem_stall = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        mem_stall = 1'b1;
        if (dmem_ready) state_d = DONE;
      end
      // DONE always returns to IDLE so the next access cannot issue on this edge
      DONE: begin
        mem_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && w_pending) begin
        req_q   <= 1'b1;
        we_q    <= mem_memwrite;
        addr_q  <= mem_alu_val;
        wdata_q <= w_store_data;
      end else if (state_q == BUSY && dmem_ready) begin
        req_q <= 1'b0;
        if (!we_q) rdata_q <= dmem_rdata;
      end
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign mem_rdata  = rdata_q;

endmodule : mem_access_ctrl
`default_nettype wire
